// File: rtl/seg_anim_sequencer.sv
// rtl/seg_anim_sequencer.sv - seven-segment animation sequencer with rate, direction, step and pattern bank
module seg_anim_sequencer #(
  parameter int TAP_BASE = 9,
  parameter int PRE_W    = 16
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic             clk;
  logic             rst;
  logic [5:0]       sync1;
  logic [5:0]       sync2;
  logic             run;
  logic             dir;
  logic             step;
  logic [1:0]       rate;
  logic             bank;
  logic             step_prev;
  logic [1:0]       warm;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] tap_mask;
  logic [4:0]       tap;
  logic [2:0]       frame;
  logic [2:0]       next_frame;
  logic             rate_chg;
  logic             tick;
  logic             step_edge;
  logic             advance;

  assign clk  = io_in[0];
  assign rst  = io_in[1];
  assign run  = sync2[0];
  assign dir  = sync2[1];
  assign step = sync2[2];
  assign rate = sync2[4:3];
  assign bank = sync2[5];

  function automatic logic [6:0] rom(input logic b, input logic [2:0] f);
    case ({b, f})
      4'h0: rom = 7'h3F;
      4'h1: rom = 7'h06;
      4'h2: rom = 7'h5B;
      4'h3: rom = 7'h4F;
      4'h4: rom = 7'h66;
      4'h5: rom = 7'h6D;
      4'h6: rom = 7'h7D;
      4'h7: rom = 7'h07;
      4'h8: rom = 7'h01;
      4'h9: rom = 7'h02;
      4'hA: rom = 7'h04;
      4'hB: rom = 7'h08;
      4'hC: rom = 7'h10;
      4'hD: rom = 7'h20;
      4'hE: rom = 7'h40;
      default: rom = 7'h00;
    endcase
  endfunction

  assign tap = 5'(TAP_BASE) + {2'b00, rate, 1'b0};

  always_comb begin
    tap_mask = '0;
    for (int i = 0; i < PRE_W; i++) tap_mask[i] = (5'(i) < tap);
  end

  // Rate change is seen the cycle before the synchronized value updates, so the
  // prescaler clears on exactly the edge where the new rate takes effect.
  assign rate_chg   = (sync1[4:3] != sync2[4:3]);
  assign tick       = run && !rate_chg && ((pre & tap_mask) == tap_mask);
  assign step_edge  = step && !step_prev;
  assign advance    = tick || (step_edge && !run);
  assign next_frame = dir ? frame - 3'd1 : frame + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      step_prev <= 1'b1;
      warm      <= 2'd0;
      pre       <= '0;
      frame     <= 3'd0;
      io_out    <= 8'h00;
    end else begin
      sync1 <= io_in[7:2];
      sync2 <= sync1;
      if (warm != 2'd2) warm <= warm + 2'd1;
      // Hold the previous-step flop high until the synchronizer holds real
      // samples, so a button held through reset is not seen as a new press.
      step_prev <= (warm == 2'd2) ? step : 1'b1;
      if (rate_chg) pre <= '0;
      else if (run) pre <= pre + PRE_W'(1);
      if (advance) begin
        frame     <= next_frame;
        io_out[7] <= ~io_out[7];
      end
      io_out[6:0] <= rom(bank, frame);
    end
  end

endmodule

// File: doc/seg_anim_sequencer.md
SEG_ANIM_SEQUENCER -- requirements
Module: seg_anim_sequencer

Interface
REQ-001 Parameter TAP_BASE, default 9: base prescaler exponent; legal range 1..9.
REQ-002 Parameter PRE_W, default 16: prescaler width; SHALL be at least TAP_BASE+7.
REQ-003 The clock SHALL be io_in[0] (input, 1 bit); it is the single clock and all state is on its rising edge.
REQ-004 The reset SHALL be io_in[1] (input, 1 bit); it is synchronous and active-high.
REQ-005 io_in[2] SHALL be an input, 1 bit: run (1 = free-running animation, 0 = paused).
REQ-006 io_in[3] SHALL be an input, 1 bit: dir (0 = frame up, 1 = frame down).
REQ-007 io_in[4] SHALL be an input, 1 bit: step button (rising edge advances one frame while paused).
REQ-008 io_in[6:5] SHALL be an input, 2 bits: rate select.
REQ-009 io_in[7] SHALL be an input, 1 bit: pattern bank select.
REQ-010 io_out[6:0] SHALL be an output, 7 bits: segments gfedcba, active-high, registered.
REQ-011 io_out[7] SHALL be an output, 1 bit: heartbeat, registered.

Function
REQ-012 io_in[7:2] SHALL each pass a 2-flop synchronizer; all behaviour below uses the synchronized values.
REQ-013 Prescaler: PRE_W-bit counter, incremented modulo 2^PRE_W every cycle while run=1, held while run=0.
REQ-014 tap = TAP_BASE + 2*rate; tick SHALL be asserted combinationally when prescaler[tap-1:0] is all ones and run=1.
REQ-015 Tick period with run held at 1 SHALL be 2^tap cycles (TAP_BASE=1: 2, 8, 32, 128 cycles for rate 0..3).
REQ-016 A change of synchronized rate SHALL clear the prescaler on that edge, with no tick that cycle; the next tick follows 2^tap cycles later.
REQ-017 Step edge = synchronized step AND NOT its registered previous value; SHALL be acted on only when run=0 and ignored when run=1.
REQ-018 Advance event = tick OR (step edge AND run=0); the two are mutually exclusive by construction.
REQ-019 Frame: 3-bit register; on advance, frame+1 mod 8 if dir=0, frame-1 mod 8 if dir=1 (7->0 and 0->7 wrap).
REQ-020 io_out[7] SHALL toggle on the edge where frame advances.
REQ-021 io_out[6:0] SHALL load ROM[bank][frame] every non-reset edge (one-cycle latency after a frame or bank change).
REQ-022 Bank 0 ROM, frames 0..7: 3F,06,5B,4F,66,6D,7D,07 (digits 0-7).
REQ-023 Bank 1 ROM, frames 0..7: 01,02,04,08,10,20,40,00 (segment chase plus blank).
REQ-024 Step latency: io_out[6:0] SHALL show the new frame on the 4th edge after the first edge that samples io_in[4]=1.
REQ-025 A dir or bank change SHALL affect only subsequent advances and loads; the current frame is not modified.

Reset
REQ-026 On a reset edge: prescaler=0, frame=0, io_out=8'h00, all synchronizer flops=0, and the step previous-value flop=1.
REQ-027 Reset has priority over every event on the same edge, including a tick or step in the same cycle.
REQ-028 With the step button held high through reset release, no step SHALL occur until it is released and pressed again.
REQ-029 On the first edge after reset release, io_out[6:0] SHALL load ROM[bank][0] (3F for bank 0).

Verification
REQ-030 TAP_BASE=1, rate=0, run=1, dir=0, bank=0: io_out[6:0] SHALL cycle 3F,06,5B,...,07,3F with one change every 2 cycles, and io_out[7] SHALL toggle with each change.
REQ-031 run=1, dir=1, starting from frame 0: the frame sequence SHALL be 0,7,6,5; with bank=1 the outputs SHALL be 01,00,40,20.
REQ-032 Switch rate 0->3 mid-count: there SHALL be no tick for 128 cycles after the synchronized change, then a tick every 128 cycles.
REQ-033 run=0 with a single step pulse: exactly one advance, visible on the 4th edge; a step pulse with run=1 SHALL produce no extra advance beyond the tick schedule.
REQ-034 Reset asserted mid-animation at frame 5 while step is held high: io_out=00, then 3F after release; no advance until step is released and re-pressed with run=0.
REQ-035 Toggle bank with run=0: io_out[6:0] SHALL switch between ROM[0][f] and ROM[1][f] for the same frame f after synchronizer delay plus 1 cycle, and the heartbeat SHALL not change.
